// File: rtl/pnode_pkg.sv
// Shared definitions for the processing-node egress path.
//   pnode_word_t : one node word {channel, sop, eop, data}
//   arb_state_t  : egress arbiter lock state
//   rr_next()    : round-robin successor with explicit wrap (works for any count)
package pnode_pkg;

  localparam int PNODE_CH_W = 12;
  localparam int PNODE_D_W  = 128;
  localparam int PNODE_W    = PNODE_CH_W + 2 + PNODE_D_W;

  typedef struct packed {
    logic [PNODE_CH_W-1:0] channel;
    logic                  sop;
    logic                  eop;
    logic [PNODE_D_W-1:0]  data;
  } pnode_word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Compare against n-1 rather than truncating, so non-power-of-2 counts wrap correctly.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first requester at or after ptr,
// wrapping at N. Purely combinational.
// Ports:
//   req     in  [N-1:0]   request vector
//   ptr     in  [PW-1:0]  highest-priority index (must be < N)
//   gnt_idx out [PW-1:0]  index of the selected requester (0 if none)
//   gnt_any out 1         at least one request present
module rr_pick #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  int cand;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/pnode_egress_arbiter.sv
// Packet-atomic round-robin merge of ncount processing-node streams onto one
// Avalon-ST egress stream with a single output register stage.
//
// State table:
//   IDLE   | no packet owns the output; grant rotates from rr_ptr
//   LOCKED | input lock_idx owns the output until its eop word is accepted
//
// Ports:
//   clock        in   single clock, posedge
//   sclr         in   asynchronous active-high reset
//   pnode_data   in   per-node word {channel, sop, eop, data}
//   pnode_valid  in   per-node word present
//   pnode_ready  out  per-node accept (combinational, one-hot or zero)
//   st_data      out  egress payload
//   st_channel   out  egress channel
//   st_sop/eop   out  egress framing
//   st_valid     out  egress word valid
//   st_ready     in   egress sink ready (ready latency 0)
//   busy         out  high while a packet is locked
//
// Optional build macro EGRESS_ARB_STATS_EN adds per-input 32-bit packet
// counters and the ports:
//   stat_sel     in   counter index
//   stat_count   out  registered read of counter[stat_sel]
module pnode_egress_arbiter
  import pnode_pkg::*;
#(
  parameter int ncount = 8,
  parameter int CH_W   = PNODE_CH_W,
  parameter int D_W    = PNODE_D_W
) (
  input  logic                              clock,
  input  logic                              sclr,
  input  logic [ncount-1:0][CH_W+D_W+1:0]   pnode_data,
  input  logic [ncount-1:0]                 pnode_valid,
  output logic [ncount-1:0]                 pnode_ready,
  output logic [D_W-1:0]                    st_data,
  output logic [CH_W-1:0]                   st_channel,
  output logic                              st_sop,
  output logic                              st_eop,
  output logic                              st_valid,
  input  logic                              st_ready,
  output logic                              busy
`ifdef EGRESS_ARB_STATS_EN
  ,
  input  logic [$clog2(ncount)-1:0]         stat_sel,
  output logic [31:0]                       stat_count
`endif
);

  localparam int W  = CH_W + D_W + 2;
  localparam int PW = $clog2(ncount);

  arb_state_t     state, state_nxt;
  logic [PW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]  lock_idx, lock_idx_nxt;
  logic [PW-1:0]  pick_idx;
  logic           pick_any;
  logic [PW-1:0]  grant_idx;
  logic           grant_vld;
  logic           grant_eop;
  logic [W-1:0]   grant_word;
  logic           out_free;
  logic           accept;

  rr_pick #(.N(ncount)) u_pick (
    .req     (pnode_valid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  always_comb begin
    grant_idx  = (state == LOCKED) ? lock_idx : pick_idx;
    grant_vld  = (state == LOCKED) ? pnode_valid[lock_idx] : pick_any;
    grant_word = pnode_data[grant_idx];
    grant_eop  = grant_word[D_W];
    out_free   = !st_valid || st_ready;
    // Ready is held low during reset so nothing is consumed while sclr is high.
    accept     = grant_vld && out_free && !sclr;
  end

  // Ready follows the grant even when the locked input is momentarily idle.
  always_comb begin
    pnode_ready = '0;
    for (int i = 0; i < ncount; i++) begin
      pnode_ready[i] = out_free && !sclr && (grant_idx == PW'(i)) &&
                       ((state == LOCKED) || pick_any);
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    lock_idx_nxt = lock_idx;
    if (accept) begin
      case (state)
        IDLE: begin
          if (grant_eop) begin
            rr_ptr_nxt = PW'(rr_next(int'(grant_idx), ncount));
          end else begin
            lock_idx_nxt = grant_idx;
            state_nxt    = LOCKED;
          end
        end
        LOCKED: begin
          if (grant_eop) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = PW'(rr_next(int'(lock_idx), ncount));
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  assign busy = (state == LOCKED);

  // Egress register: a load wins over a drain, so back-to-back words keep st_valid high.
  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      st_valid   <= 1'b0;
      st_data    <= '0;
      st_channel <= '0;
      st_sop     <= 1'b0;
      st_eop     <= 1'b0;
    end else if (accept) begin
      st_valid   <= 1'b1;
      st_channel <= grant_word[W-1 -: CH_W];
      st_sop     <= grant_word[D_W+1];
      st_eop     <= grant_word[D_W];
      st_data    <= grant_word[D_W-1:0];
    end else if (st_ready) begin
      st_valid   <= 1'b0;
    end
  end

`ifdef EGRESS_ARB_STATS_EN
  logic [31:0] stat_cnt [ncount];

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      for (int i = 0; i < ncount; i++) stat_cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      if (accept && grant_eop) begin
        stat_cnt[grant_idx] <= stat_cnt[grant_idx] + 32'd1;
      end
      stat_count <= (int'(stat_sel) < ncount) ? stat_cnt[stat_sel] : '0;
    end
  end
`endif

endmodule
